// File: rtl/de_scoreboard_ctrl.sv
// rtl/de_scoreboard_ctrl.sv - decode-stage scoreboard issue controller with control-flow hold
// Optional same-cycle WB bypass in the hazard check: define SCOREBOARD_WB_BYPASS_EN.
module de_scoreboard_ctrl #(
  parameter int NREGS     = 32,
  parameter int REGNOBITS = 5,
  parameter int CNTBITS   = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 de_valid,
  input  logic [REGNOBITS-1:0] de_rs1,
  input  logic [REGNOBITS-1:0] de_rs2,
  input  logic                 de_use_rs1,
  input  logic                 de_use_rs2,
  input  logic                 de_wr_reg,
  input  logic [REGNOBITS-1:0] de_rd,
  input  logic                 de_is_ctrl,
  input  logic                 agex_ctrl_resolved,
  input  logic                 agex_mispred,
  input  logic                 wb_wr_reg,
  input  logic [REGNOBITS-1:0] wb_rd,
  output logic                 issue,
  output logic                 stall_DE,
  output logic                 flush_DE,
  output logic [NREGS-1:0]     busy_mask,
  output logic                 sb_err
);

  typedef enum logic [1:0] {IDLE, WAIT_CTRL, FLUSH} state_t;

  localparam logic [CNTBITS-1:0] CNT_MAX = '1;
  localparam logic [CNTBITS-1:0] CNT_ONE = CNTBITS'(1);

  state_t state, state_next;
  logic [CNTBITS-1:0] cnt      [NREGS];
  logic [CNTBITS-1:0] cnt_next [NREGS];
  logic rs1_busy, rs2_busy, hazard, waw_limit;
  logic inc, dec, err_hit;

  assign dec = wb_wr_reg && (wb_rd != '0);

`ifdef SCOREBOARD_WB_BYPASS_EN
  // A source retiring its last pending write this cycle reads regval_WB in DE.
  logic wb_match_rs1, wb_match_rs2;
  assign wb_match_rs1 = dec && (wb_rd == de_rs1) && (cnt[de_rs1] == CNT_ONE);
  assign wb_match_rs2 = dec && (wb_rd == de_rs2) && (cnt[de_rs2] == CNT_ONE);
  assign rs1_busy = de_use_rs1 && (de_rs1 != '0) && (cnt[de_rs1] != '0) && !wb_match_rs1;
  assign rs2_busy = de_use_rs2 && (de_rs2 != '0) && (cnt[de_rs2] != '0) && !wb_match_rs2;
`else
  assign rs1_busy = de_use_rs1 && (de_rs1 != '0) && (cnt[de_rs1] != '0);
  assign rs2_busy = de_use_rs2 && (de_rs2 != '0) && (cnt[de_rs2] != '0);
`endif

  assign hazard    = rs1_busy || rs2_busy;
  assign waw_limit = de_wr_reg && (de_rd != '0) && (cnt[de_rd] == CNT_MAX);

  always_comb begin
    issue      = 1'b0;
    stall_DE   = 1'b1;
    flush_DE   = 1'b0;
    state_next = state;
    if (reset) begin
      issue    = de_valid && !hazard && !waw_limit && (state == IDLE);
      stall_DE = (de_valid && !issue) || (state != IDLE);
      flush_DE = (state == FLUSH);
    end
    case (state)
      IDLE:      if (issue && de_is_ctrl) state_next = WAIT_CTRL;
      WAIT_CTRL: if (agex_ctrl_resolved) state_next = agex_mispred ? FLUSH : IDLE;
      FLUSH:     state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  assign inc = issue && de_wr_reg && (de_rd != '0);

  // Issue and retire of the same register in one cycle cancel out.
  always_comb begin
    err_hit = 1'b0;
    for (int i = 0; i < NREGS; i++) begin
      cnt_next[i] = cnt[i];
    end
    for (int i = 1; i < NREGS; i++) begin
      if (inc && (de_rd == REGNOBITS'(i)) && !(dec && (wb_rd == REGNOBITS'(i)))) begin
        cnt_next[i] = cnt[i] + CNT_ONE;
      end else if (dec && (wb_rd == REGNOBITS'(i)) && !(inc && (de_rd == REGNOBITS'(i)))) begin
        if (cnt[i] != '0) cnt_next[i] = cnt[i] - CNT_ONE;
        else              err_hit     = 1'b1;
      end
    end
    cnt_next[0] = '0;
  end

  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      busy_mask[i] = (cnt[i] != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      sb_err <= 1'b0;
      for (int i = 0; i < NREGS; i++) cnt[i] <= '0;
    end else begin
      state  <= state_next;
      sb_err <= sb_err || err_hit;
      for (int i = 0; i < NREGS; i++) cnt[i] <= cnt_next[i];
    end
  end

endmodule

// File: tb/tb_de_scoreboard_ctrl.sv
// tb/tb_de_scoreboard_ctrl.sv - directed self-checking bench for de_scoreboard_ctrl
module tb_de_scoreboard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        de_valid;
  logic [4:0]  de_rs1, de_rs2, de_rd, wb_rd;
  logic        de_use_rs1, de_use_rs2, de_wr_reg, de_is_ctrl;
  logic        agex_ctrl_resolved, agex_mispred, wb_wr_reg;
  logic        issue, stall_DE, flush_DE, sb_err;
  logic [31:0] busy_mask;

  int n_checks = 0;
  int n_fail   = 0;

  de_scoreboard_ctrl #(.NREGS(32), .REGNOBITS(5), .CNTBITS(2)) dut (
    .clk(clk), .reset(reset), .de_valid(de_valid),
    .de_rs1(de_rs1), .de_rs2(de_rs2), .de_use_rs1(de_use_rs1), .de_use_rs2(de_use_rs2),
    .de_wr_reg(de_wr_reg), .de_rd(de_rd), .de_is_ctrl(de_is_ctrl),
    .agex_ctrl_resolved(agex_ctrl_resolved), .agex_mispred(agex_mispred),
    .wb_wr_reg(wb_wr_reg), .wb_rd(wb_rd),
    .issue(issue), .stall_DE(stall_DE), .flush_DE(flush_DE),
    .busy_mask(busy_mask), .sb_err(sb_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic instr(input logic v, input logic [4:0] rs1, input logic u1,
                       input logic [4:0] rs2, input logic u2,
                       input logic wr, input logic [4:0] rd, input logic ctrl);
    de_valid = v; de_rs1 = rs1; de_use_rs1 = u1; de_rs2 = rs2; de_use_rs2 = u2;
    de_wr_reg = wr; de_rd = rd; de_is_ctrl = ctrl;
  endtask

  task automatic wb(input logic w, input logic [4:0] rd);
    wb_wr_reg = w; wb_rd = rd;
  endtask

  task automatic resolve(input logic r, input logic m);
    agex_ctrl_resolved = r; agex_mispred = m;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    instr(1, 5'd2, 1, 5'd3, 1, 1, 5'd1, 0);
    wb(0, 0);
    resolve(0, 0);
    cyc(); settle();
    check("rst_stall", stall_DE, 1);
    check("rst_issue", issue, 0);
    cyc(); settle();
    check("rst_busy", busy_mask, 0);
    check("rst_err", sb_err, 0);
    check("rst_flush", flush_DE, 0);

    reset = 1'b1; settle();
    check("first_issue", issue, 1);
    check("first_stall", stall_DE, 0);
    cyc();
    check("first_busy", busy_mask, 32'h0000_0002);
    instr(0, 0, 0, 0, 0, 0, 0, 0); wb(1, 5'd1); settle();
    check("idle_stall", stall_DE, 0);
    cyc(); wb(0, 0);
    check("x1_retired", busy_mask, 0);

    // RAW on x5
    instr(1, 5'd0, 1, 5'd0, 0, 1, 5'd5, 0); settle();
    check("addi_issue", issue, 1);
    cyc();
    check("x5_busy", busy_mask, 32'h0000_0020);
    instr(1, 5'd5, 1, 5'd5, 1, 1, 5'd6, 0); settle();
    check("raw_issue", issue, 0);
    check("raw_stall", stall_DE, 1);
    cyc();
    check("raw_hold_busy", busy_mask, 32'h0000_0020);
    wb(1, 5'd5); settle();
    check("raw_wb_cycle_issue", issue, 0);
    cyc(); wb(0, 0);
    check("x5_clear", busy_mask, 0);
    settle();
    check("raw_next_issue", issue, 1);
    cyc();
    check("x6_busy", busy_mask, 32'h0000_0040);
    instr(0, 0, 0, 0, 0, 0, 0, 0); wb(1, 5'd6);
    cyc(); wb(0, 0);

    // WAW saturation on x7
    instr(1, 5'd0, 1, 5'd0, 0, 1, 5'd7, 0);
    for (int k = 0; k < 3; k++) begin
      settle();
      check("waw_issue", issue, 1);
      cyc();
    end
    check("x7_busy", busy_mask, 32'h0000_0080);
    settle();
    check("waw_sat_issue", issue, 0);
    check("waw_sat_stall", stall_DE, 1);
    cyc();
    wb(1, 5'd7); settle();
    check("waw_wb_cycle_issue", issue, 0);
    cyc(); wb(0, 0); settle();
    check("waw_fourth_issue", issue, 1);
    cyc();
    instr(0, 0, 0, 0, 0, 0, 0, 0); wb(1, 5'd7);
    cyc(); cyc();
    check("x7_still_busy", busy_mask, 32'h0000_0080);
    cyc(); wb(0, 0);
    check("x7_clear", busy_mask, 0);

    // simultaneous issue and retire of x9, then x0 writer
    instr(1, 5'd0, 1, 5'd0, 0, 1, 5'd9, 0);
    cyc();
    wb(1, 5'd9); settle();
    check("x9_sim_issue", issue, 1);
    cyc(); wb(0, 0);
    check("x9_sim_busy", busy_mask, 32'h0000_0200);
    instr(1, 5'd0, 1, 5'd0, 0, 1, 5'd0, 0); settle();
    check("x0_issue", issue, 1);
    cyc();
    check("x0_busy", busy_mask, 32'h0000_0200);
    instr(0, 0, 0, 0, 0, 0, 0, 0); wb(1, 5'd9);
    cyc(); wb(0, 0);
    check("x9_clear", busy_mask, 0);

    // branch with mispredict
    instr(1, 5'd0, 1, 5'd0, 1, 0, 5'd0, 1); settle();
    check("beq_issue", issue, 1);
    cyc();
    instr(1, 5'd2, 1, 5'd3, 1, 1, 5'd0, 0); resolve(1, 1); settle();
    check("mp_n1_issue", issue, 0);
    check("mp_n1_stall", stall_DE, 1);
    check("mp_n1_flush", flush_DE, 0);
    cyc(); resolve(0, 0); settle();
    check("mp_n2_flush", flush_DE, 1);
    check("mp_n2_issue", issue, 0);
    check("mp_n2_stall", stall_DE, 1);
    cyc(); settle();
    check("mp_n3_issue", issue, 1);
    check("mp_n3_flush", flush_DE, 0);
    cyc();

    // branch without mispredict; stray resolve in IDLE is ignored
    instr(1, 5'd0, 1, 5'd0, 1, 0, 5'd0, 1); settle();
    check("bne_issue", issue, 1);
    cyc();
    instr(1, 5'd2, 1, 5'd3, 1, 1, 5'd0, 0); resolve(1, 0); settle();
    check("np_n1_issue", issue, 0);
    check("np_n1_flush", flush_DE, 0);
    cyc(); resolve(1, 1); settle();
    check("np_n2_issue", issue, 1);
    check("np_n2_flush", flush_DE, 0);
    cyc(); resolve(0, 0); settle();
    check("np_n3_flush", flush_DE, 0);
    check("np_n3_issue", issue, 1);
    cyc();

    // retire underflow on x4
    instr(0, 0, 0, 0, 0, 0, 0, 0); wb(1, 5'd4);
    cyc(); wb(0, 0);
    check("err_set", sb_err, 1);
    check("err_busy", busy_mask, 0);
    cyc();
    check("err_sticky", sb_err, 1);

    // JAL x3 enters WAIT_CTRL, then mid-operation reset
    instr(1, 5'd0, 0, 5'd0, 0, 1, 5'd3, 1); settle();
    check("jal_issue", issue, 1);
    cyc();
    instr(0, 0, 0, 0, 0, 0, 0, 0); settle();
    check("jal_busy", busy_mask, 32'h0000_0008);
    check("jal_wait_stall", stall_DE, 1);
    reset = 1'b0;
    cyc();
    check("rst2_err", sb_err, 0);
    check("rst2_busy", busy_mask, 0);
    reset = 1'b1; settle();
    check("rst2_idle_stall", stall_DE, 0);
    check("rst2_flush", flush_DE, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
